// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM stage (EX/MEM register, LSU, MEM/WB register).
// Holds the access-size encodings, the FSM state type, the EX/MEM payload struct
// and an alignment helper used by the top level.
package mem_access_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 8;

  localparam logic [XLEN-1:0] ZERO = '0;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic {
    MEMST_IDLE   = 1'b0,
    MEMST_ACCESS = 1'b1
  } mem_state_e;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   wdata;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              is_unsigned;
  } exmem_t;

  // Natural alignment check; size 2'b11 behaves as a word access
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      MEM_SIZE_B: ok = 1'b1;
      MEM_SIZE_H: ok = !addr_lo[0];
      default:    ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size (byte/half/word, 11 = word)
//   is_unsigned in  1   zero-extend loads instead of sign-extend
//   st_data     in  32  store data (low bits significant for byte/half)
//   ld_raw      in  32  raw word returned by memory
//   be_c        out 4   byte enables
//   st_lanes_c  out 32  store data replicated across byte lanes
//   ld_data_c   out 32  selected and extended load data
module mem_access_lsu_align
  import mem_access_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_raw,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] st_lanes_c,
  output logic [XLEN-1:0] ld_data_c
);

  logic [XLEN-1:0] ld_shift;

  // Lane select, replication and extension per access size
  always_comb begin
    be_c       = 4'b1111;
    st_lanes_c = st_data;
    ld_data_c  = ld_raw;
    ld_shift   = ld_raw >> {addr_lo, 3'b000};
    case (size)
      MEM_SIZE_B: begin
        be_c       = 4'b0001 << addr_lo;
        st_lanes_c = {4{st_data[7:0]}};
        ld_data_c  = {{24{!is_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      end
      MEM_SIZE_H: begin
        be_c       = 4'b0011 << {addr_lo[1], 1'b0};
        st_lanes_c = {2{st_data[15:0]}};
        ld_data_c  = {{16{!is_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the rv32i pipeline: EX/MEM register, data-memory req/ack FSM with
// timeout, and MEM/WB register. Also sources EX-stage forwarding signals.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   ex_*                           instruction leaving EX (valid, alu result, store data, rd, ctrl)
//   mem_stall                      hold IF/ID/EX while a memory access is waiting for ack
//   dmem_req/we/addr/be/wdata      data-memory request (combinational, stable until ack)
//   dmem_ack, dmem_rdata           memory response
//   exmem_reg_write/rd/wdata       EX/MEM forwarding source (loads never forward)
//   memwb_reg_write/rd, wb_reg_wdata  MEM/WB writeback
//   misalign, bus_err              one-cycle pulses, aligned with the dropped MEM/WB write
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic [DATA_WIDTH-1:0]  ex_alu_result,
  input  logic [DATA_WIDTH-1:0]  ex_mem_wdata,
  input  logic [RADDR_WIDTH-1:0] ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic [1:0]             ex_mem_size,
  input  logic                   ex_mem_unsigned,
  output logic                   mem_stall,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_WIDTH-1:0]  dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [DATA_WIDTH-1:0]  dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [DATA_WIDTH-1:0]  dmem_rdata,
  output logic                   exmem_reg_write,
  output logic [RADDR_WIDTH-1:0] exmem_reg_rd,
  output logic [DATA_WIDTH-1:0]  exmem_reg_wdata,
  output logic                   memwb_reg_write,
  output logic [RADDR_WIDTH-1:0] memwb_reg_rd,
  output logic [DATA_WIDTH-1:0]  wb_reg_wdata,
  output logic                   misalign,
  output logic                   bus_err
);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  exmem_t            exmem_q, exmem_d;
  logic              memwb_reg_write_q, memwb_reg_write_d;
  logic [REG_AW-1:0] memwb_reg_rd_q, memwb_reg_rd_d;
  logic [XLEN-1:0]   wb_reg_wdata_q, wb_reg_wdata_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic              mem_op_c;
  logic              aligned_c;
  logic              misal_c;
  logic              req_c;
  logic              abort_c;
  logic              stall_c;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   st_lanes_c;
  logic [XLEN-1:0]   ld_data_c;

  assign mem_op_c  = exmem_q.valid & (exmem_q.mem_read | exmem_q.mem_write);
  assign aligned_c = is_aligned(exmem_q.size, exmem_q.alu_result[1:0]);
  assign misal_c   = mem_op_c & !aligned_c;

  mem_access_lsu_align u_lsu_align (
    .addr_lo     (exmem_q.alu_result[1:0]),
    .size        (exmem_q.size),
    .is_unsigned (exmem_q.is_unsigned),
    .st_data     (exmem_q.wdata),
    .ld_raw      (dmem_rdata),
    .be_c        (be_c),
    .st_lanes_c  (st_lanes_c),
    .ld_data_c   (ld_data_c)
  );

  // Next state, timeout counter and both pipeline register updates
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    exmem_d           = exmem_q;
    memwb_reg_write_d = 1'b0;
    memwb_reg_rd_d    = memwb_reg_rd_q;
    wb_reg_wdata_d    = wb_reg_wdata_q;
    misalign_d        = 1'b0;
    bus_err_d         = 1'b0;
    req_c             = 1'b0;
    abort_c           = 1'b0;

    // IDLE issues in the first MEM cycle so a zero-wait ack needs no stall
    unique case (state_q)
      MEMST_IDLE:   req_c = mem_op_c & aligned_c;
      MEMST_ACCESS: begin
        if (cnt_q == CNT_W'(TIMEOUT)) abort_c = 1'b1;
        else                           req_c   = 1'b1;
      end
    endcase

    stall_c = req_c & !dmem_ack;

    if (req_c) begin
      if (dmem_ack) begin
        state_d = MEMST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = MEMST_ACCESS;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end else if (abort_c) begin
      state_d = MEMST_IDLE;
      cnt_d   = '0;
    end

    // Pipeline advances whenever no access is waiting
    if (!stall_c) begin
      exmem_d.valid       = ex_valid;
      exmem_d.alu_result  = ex_alu_result;
      exmem_d.wdata       = ex_mem_wdata;
      exmem_d.rd          = ex_rd;
      exmem_d.reg_write   = ex_reg_write;
      exmem_d.mem_read    = ex_mem_read;
      exmem_d.mem_write   = ex_mem_write;
      exmem_d.size        = ex_mem_size;
      exmem_d.is_unsigned = ex_mem_unsigned;

      memwb_reg_write_d = exmem_q.valid & exmem_q.reg_write & !misal_c & !abort_c;
      memwb_reg_rd_d    = exmem_q.rd;
      wb_reg_wdata_d    = exmem_q.mem_read ? ld_data_c : exmem_q.alu_result;
      misalign_d        = misal_c;
      bus_err_d         = abort_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= MEMST_IDLE;
      cnt_q             <= '0;
      exmem_q           <= '0;
      memwb_reg_write_q <= 1'b0;
      memwb_reg_rd_q    <= '0;
      wb_reg_wdata_q    <= '0;
      misalign_q        <= 1'b0;
      bus_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      exmem_q           <= exmem_d;
      memwb_reg_write_q <= memwb_reg_write_d;
      memwb_reg_rd_q    <= memwb_reg_rd_d;
      wb_reg_wdata_q    <= wb_reg_wdata_d;
      misalign_q        <= misalign_d;
      bus_err_q         <= bus_err_d;
    end
  end

  // Request fields are gated by req so the bus idles at zero
  assign mem_stall       = stall_c;
  assign dmem_req        = req_c;
  assign dmem_we         = req_c & exmem_q.mem_write;
  assign dmem_addr       = req_c ? {exmem_q.alu_result[XLEN-1:2], 2'b00} : ZERO;
  assign dmem_be         = req_c ? be_c : 4'b0000;
  assign dmem_wdata      = req_c ? st_lanes_c : ZERO;

  assign exmem_reg_write = exmem_q.valid & exmem_q.reg_write & !exmem_q.mem_read;
  assign exmem_reg_rd    = exmem_q.rd;
  assign exmem_reg_wdata = exmem_q.alu_result;

  assign memwb_reg_write = memwb_reg_write_q;
  assign memwb_reg_rd    = memwb_reg_rd_q;
  assign wb_reg_wdata    = wb_reg_wdata_q;
  assign misalign        = misalign_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed steps plus randomized ops against a
// word-array memory and an arithmetic reference model of the MEM stage.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_mem_wdata;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        exmem_reg_write;
  logic [4:0]  exmem_reg_rd;
  logic [31:0] exmem_reg_wdata;
  logic        memwb_reg_write;
  logic [4:0]  memwb_reg_rd;
  logic [31:0] wb_reg_wdata;
  logic        misalign;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  mem_access #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .ex_alu_result   (ex_alu_result),
    .ex_mem_wdata    (ex_mem_wdata),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_size     (ex_mem_size),
    .ex_mem_unsigned (ex_mem_unsigned),
    .mem_stall       (mem_stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_ack        (dmem_ack),
    .dmem_rdata      (dmem_rdata),
    .exmem_reg_write (exmem_reg_write),
    .exmem_reg_rd    (exmem_reg_rd),
    .exmem_reg_wdata (exmem_reg_wdata),
    .memwb_reg_write (memwb_reg_write),
    .memwb_reg_rd    (memwb_reg_rd),
    .wb_reg_wdata    (wb_reg_wdata),
    .misalign        (misalign),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ctl"}, 32'({mem_stall, dmem_req, dmem_we, misalign, bus_err,
                            exmem_reg_write, memwb_reg_write}), 32'h0);
    chk({tag, ".data"}, dmem_addr | dmem_wdata | exmem_reg_wdata | wb_reg_wdata, 32'h0);
    chk({tag, ".idx"}, 32'({dmem_be, exmem_reg_rd, memwb_reg_rd}), 32'h0);
  endtask

  task automatic bubble();
    ex_valid        = 1'b0;
    ex_alu_result   = $urandom;
    ex_mem_wdata    = $urandom;
    ex_rd           = 5'($urandom);
    ex_reg_write    = 1'($urandom);
    ex_mem_read     = 1'($urandom);
    ex_mem_write    = 1'($urandom);
    ex_mem_size     = 2'($urandom);
    ex_mem_unsigned = 1'($urandom);
  endtask

  // Issue one instruction, answer the bus after lat wait cycles (lat<0: never), check it.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input logic rw, input int lat);
    logic        mem_op, ok, exp_to, exp_mis, exp_we, stable, done;
    logic [3:0]  exp_be, obs_be;
    logic [31:0] exp_wd, exp_wb, w, sh, obs_addr, obs_wd;
    logic        obs_we;
    int          exp_reqs, exp_stalls, reqs, stalls, waited;

    // reference model
    mem_op = ld | st;
    if (sz == 2'd0)      ok = 1'b1;
    else if (sz == 2'd1) ok = (a % 2) == 0;
    else                 ok = (a % 4) == 0;
    if (sz == 2'd0)      exp_be = 4'(1 << a[1:0]);
    else if (sz == 2'd1) exp_be = 4'(3 << a[1:0]);
    else                 exp_be = 4'hF;
    if (sz == 2'd0)      exp_wd = {24'h0, d[7:0]} * 32'h01010101;
    else if (sz == 2'd1) exp_wd = {16'h0, d[15:0]} * 32'h00010001;
    else                 exp_wd = d;
    exp_to     = mem_op && ok && (lat < 0 || lat >= TO);
    exp_mis    = mem_op && !ok;
    exp_reqs   = !(mem_op && ok) ? 0 : (exp_to ? TO : lat + 1);
    exp_stalls = !(mem_op && ok) ? 0 : (exp_to ? TO : lat);
    exp_we     = rw && !exp_mis && !exp_to;
    w  = mem[a[9:2]];
    sh = w >> (32'(a[1:0]) * 8);
    if (sz == 2'd0) begin
      exp_wb = sh & 32'hFF;
      if (!uns && exp_wb[7]) exp_wb = exp_wb | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      exp_wb = sh & 32'hFFFF;
      if (!uns && exp_wb[15]) exp_wb = exp_wb | 32'hFFFF0000;
    end else begin
      exp_wb = w;
    end
    if (!ld) exp_wb = a;

    ex_valid = 1'b1; ex_alu_result = a; ex_mem_wdata = d; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = ld; ex_mem_write = st;
    ex_mem_size = sz; ex_mem_unsigned = uns;
    @(posedge clk);
    @(negedge clk);
    bubble();

    chk({tag, ".fwd_we"}, 32'(exmem_reg_write), 32'(rw & !ld));
    chk({tag, ".fwd_rd"}, 32'(exmem_reg_rd), 32'(rd));
    chk({tag, ".fwd_wd"}, exmem_reg_wdata, a);

    reqs = 0; stalls = 0; waited = 0; done = 1'b0; stable = 1'b1;
    obs_addr = '0; obs_be = '0; obs_wd = '0; obs_we = 1'b0;
    for (int cyc = 0; cyc < TO + 8 && !done; cyc++) begin
      dmem_ack   = dmem_req && (waited == lat);
      dmem_rdata = mem[dmem_addr[9:2]];
      #1;
      if (dmem_req) begin
        if (reqs == 0) begin
          obs_addr = dmem_addr; obs_be = dmem_be; obs_wd = dmem_wdata; obs_we = dmem_we;
        end else if (obs_addr !== dmem_addr || obs_be !== dmem_be ||
                     obs_wd !== dmem_wdata || obs_we !== dmem_we) begin
          stable = 1'b0;
        end
        reqs++;
        waited++;
      end
      if (mem_stall) stalls++;
      if (!mem_stall) done = 1'b1;
      @(negedge clk);
    end
    dmem_ack = 1'b0;

    chk({tag, ".done"}, 32'(done), 32'h1);
    chk({tag, ".reqs"}, 32'(reqs), 32'(exp_reqs));
    chk({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
    if (exp_reqs > 0) begin
      chk({tag, ".addr"}, obs_addr, {a[31:2], 2'b00});
      chk({tag, ".be"}, 32'(obs_be), 32'(exp_be));
      chk({tag, ".we"}, 32'(obs_we), 32'(st));
      if (st) chk({tag, ".wdata"}, obs_wd, exp_wd);
      chk({tag, ".stable"}, 32'(stable), 32'h1);
    end
    chk({tag, ".wb_we"}, 32'(memwb_reg_write), 32'(exp_we));
    chk({tag, ".misalign"}, 32'(misalign), 32'(exp_mis));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_to));
    if (exp_we) begin
      chk({tag, ".wb_rd"}, 32'(memwb_reg_rd), 32'(rd));
      chk({tag, ".wb_data"}, wb_reg_wdata, exp_wb);
    end
    @(negedge clk);
    chk({tag, ".pulse_end"}, 32'({memwb_reg_write, misalign, bus_err}), 32'h0);

    if (st && ok && !exp_to) begin
      for (int b = 0; b < 4; b++)
        if (exp_be[b]) mem[a[9:2]][8*b +: 8] = exp_wd[8*b +: 8];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          kind, lat;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sw_0x100",  1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 5'd0, 1'b0, 0);
    run_op("lw_0x100",  1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 1'b1, 0);
    mem[8'h40] = 32'h80FFFFFF;
    run_op("lb_0x103",  1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1, 1);
    run_op("lbu_0x103", 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 2);
    run_op("sh_0x202",  1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 5'd0, 1'b0, 0);
    run_op("lh_0x202",  1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 5'd8, 1'b1, 0);
    run_op("lhu_0x202", 1'b1, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 5'd9, 1'b1, 0);
    run_op("lw_wait3",  1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd10, 1'b1, 3);
    run_op("lw_mis",    1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd11, 1'b1, 0);
    run_op("sh_mis",    1'b0, 1'b1, 2'd1, 1'b0, 32'h201, 32'hFFFF, 5'd0, 1'b0, 0);
    run_op("lw_noack",  1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd12, 1'b1, -1);
    run_op("sw_noack",  1'b0, 1'b1, 2'd3, 1'b0, 32'h108, 32'hCAFEF00D, 5'd0, 1'b0, 4);
    run_op("alu_op",    1'b0, 1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 5'd13, 1'b1, 0);

    // Reset while an access is outstanding
    ex_valid = 1'b1; ex_alu_result = 32'h10; ex_mem_wdata = 32'h0; ex_rd = 5'd3;
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_mem_size = 2'd2; ex_mem_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bubble();
    @(negedge clk);
    #1;
    chk("rst_mid.req_before", 32'(dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.req_dropped", 32'(dmem_req), 32'h0);
    chk("rst_mid.stall_dropped", 32'(mem_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_mid.after");
    @(negedge clk);
    run_op("post_rst_lw", 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd14, 1'b1, 1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      a    = (kind == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if (kind != 0 && $urandom_range(0, 3) != 0) begin
        if (sz == 2'd1)      a = a & ~32'h1;
        else if (sz != 2'd0) a = a & ~32'h3;
      end
      lat = $urandom_range(0, 5);
      if (lat == 5) lat = -1;
      run_op($sformatf("rnd%0d", i), kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)),
             a, $urandom, 5'($urandom_range(0, 31)), kind != 2, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
